// File: rtl/dds_sweep_ctrl_if.sv
// Handshake/bus bundle for dds_sweep_ctrl: byte-wide configuration port,
// start/stop requests, and the frequency-word output with its status pulses.
// Ports: icfg_wr/icfg_addr/icfg_data, istart, istop (to DUT); ofreq_word,
//        ofreq_vld, ophase_clr, obusy, odone, oerr (from DUT).
interface dds_sweep_ctrl_if #(
  parameter int FW_W = 24
);
  logic            icfg_wr;
  logic [3:0]      icfg_addr;
  logic [7:0]      icfg_data;
  logic            istart;
  logic            istop;
  logic [FW_W-1:0] ofreq_word;
  logic            ofreq_vld;
  logic            ophase_clr;
  logic            obusy;
  logic            odone;
  logic            oerr;

  // Controller side: drives configuration and requests, observes outputs.
  modport master (
    output icfg_wr, icfg_addr, icfg_data, istart, istop,
    input  ofreq_word, ofreq_vld, ophase_clr, obusy, odone, oerr
  );

  // Sweep block side.
  modport slave (
    input  icfg_wr, icfg_addr, icfg_data, istart, istop,
    output ofreq_word, ofreq_vld, ophase_clr, obusy, odone, oerr
  );
endinterface

// File: rtl/dds_sweep_ctrl.sv
// DDS frequency sweep controller: steps a frequency word from start to stop
// (optionally back down, optionally repeating), holding each word dwell+1 cycles.
// Ports: iclk, irstn (async active-low), io_bus (dds_sweep_ctrl_if.slave).
module dds_sweep_ctrl #(
  parameter int FW_W    = 24,
  parameter int DWELL_W = 16
) (
  input  logic                  iclk,
  input  logic                  irstn,
  dds_sweep_ctrl_if.slave       io_bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_UP   = 2'd1,
    S_DOWN = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Shadow registers, written byte-wise at any time.
  logic [23:0] r_sh_start;
  logic [23:0] r_sh_stop;
  logic [15:0] r_sh_step;
  logic [15:0] r_sh_dwell;
  logic [1:0]  r_sh_mode;

  // Active registers, frozen for the duration of a sweep.
  logic [FW_W-1:0]    r_start;
  logic [FW_W-1:0]    r_stop;
  logic [FW_W-1:0]    r_step;
  logic [DWELL_W-1:0] r_dwell;
  logic [1:0]         r_mode;

  logic [FW_W-1:0]    r_word;
  logic [DWELL_W-1:0] r_cnt;
  logic               r_vld;
  logic               r_clr;
  logic               r_done;
  logic               r_err;

  logic [FW_W-1:0]    w_sh_start;
  logic [FW_W-1:0]    w_sh_stop;
  logic [FW_W-1:0]    w_sh_step;
  logic [DWELL_W-1:0] w_sh_dwell;
  logic [FW_W:0]      w_sum;
  logic [FW_W:0]      w_diff;
  logic [FW_W-1:0]    w_up_nxt;
  logic [FW_W-1:0]    w_down_nxt;
  logic               w_expire;
  logic               w_tri;

  logic               w_load;
  logic [FW_W-1:0]    w_word_nxt;
  logic [DWELL_W-1:0] w_cnt_nxt;
  logic               w_clr;
  logic               w_done;
  logic               w_err;
  logic               w_copy;

  assign w_sh_start = FW_W'(r_sh_start);
  assign w_sh_stop  = FW_W'(r_sh_stop);
  assign w_sh_step  = FW_W'(r_sh_step);
  assign w_sh_dwell = DWELL_W'(r_sh_dwell);

  // One extra bit so overflow past the top of the word range still clamps to stop,
  // and so a borrow below zero still clamps to start.
  assign w_sum      = {1'b0, r_word} + {1'b0, r_step};
  assign w_diff     = {1'b0, r_word} - {1'b0, r_step};
  assign w_up_nxt   = (w_sum >= {1'b0, r_stop}) ? r_stop : w_sum[FW_W-1:0];
  assign w_down_nxt = (w_diff[FW_W] || (w_diff[FW_W-1:0] <= r_start)) ? r_start
                                                                       : w_diff[FW_W-1:0];

  assign w_expire   = (r_cnt == r_dwell);
  // A single-word sweep has nothing to descend through, so triangle is ignored.
  assign w_tri      = r_mode[0] && (r_start != r_stop);

  // Shadow register file.
  always_ff @(posedge iclk or negedge irstn) begin
    if (!irstn) begin
      r_sh_start <= 24'd1;
      r_sh_stop  <= 24'd1;
      r_sh_step  <= 16'd1;
      r_sh_dwell <= 16'd0;
      r_sh_mode  <= 2'd0;
    end else if (io_bus.icfg_wr) begin
      case (io_bus.icfg_addr)
        4'd0:    r_sh_start[7:0]   <= io_bus.icfg_data;
        4'd1:    r_sh_start[15:8]  <= io_bus.icfg_data;
        4'd2:    r_sh_start[23:16] <= io_bus.icfg_data;
        4'd3:    r_sh_stop[7:0]    <= io_bus.icfg_data;
        4'd4:    r_sh_stop[15:8]   <= io_bus.icfg_data;
        4'd5:    r_sh_stop[23:16]  <= io_bus.icfg_data;
        4'd6:    r_sh_step[7:0]    <= io_bus.icfg_data;
        4'd7:    r_sh_step[15:8]   <= io_bus.icfg_data;
        4'd8:    r_sh_dwell[7:0]   <= io_bus.icfg_data;
        4'd9:    r_sh_dwell[15:8]  <= io_bus.icfg_data;
        4'd10:   r_sh_mode         <= io_bus.icfg_data[1:0];
        default: ;
      endcase
    end
  end

  // State register.
  always_ff @(posedge iclk or negedge irstn) begin
    if (!irstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and datapath control.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_word_nxt  = r_word;
    w_cnt_nxt   = r_cnt;
    w_clr       = 1'b0;
    w_done      = 1'b0;
    w_err       = 1'b0;
    w_copy      = 1'b0;

    case (r_state)
      S_IDLE: begin
        // istop takes priority, so a simultaneous istart is silently dropped.
        if (io_bus.istart && !io_bus.istop) begin
          if ((w_sh_start > w_sh_stop) || (w_sh_step == '0)) begin
            w_err = 1'b1;
          end else begin
            w_copy      = 1'b1;
            w_state_nxt = S_UP;
            w_load      = 1'b1;
            w_word_nxt  = w_sh_start;
            w_clr       = 1'b1;
            w_cnt_nxt   = '0;
          end
        end
      end

      S_UP: begin
        if (io_bus.istop) begin
          w_state_nxt = S_IDLE;
        end else if (w_expire) begin
          w_cnt_nxt = '0;
          if (r_word == r_stop) begin
            if (w_tri) begin
              w_state_nxt = S_DOWN;
              w_load      = 1'b1;
              w_word_nxt  = w_down_nxt;
            end else if (r_mode[1]) begin
              w_load     = 1'b1;
              w_word_nxt = r_start;
              w_clr      = 1'b1;
            end else begin
              w_state_nxt = S_IDLE;
              w_done      = 1'b1;
            end
          end else begin
            w_load     = 1'b1;
            w_word_nxt = w_up_nxt;
          end
        end else begin
          w_cnt_nxt = r_cnt + DWELL_W'(1);
        end
      end

      S_DOWN: begin
        if (io_bus.istop) begin
          w_state_nxt = S_IDLE;
        end else if (w_expire) begin
          w_cnt_nxt = '0;
          if (r_word == r_start) begin
            if (r_mode[1]) begin
              // Turn around without a phase clear: the waveform stays continuous.
              w_state_nxt = S_UP;
              w_load      = 1'b1;
              w_word_nxt  = w_up_nxt;
            end else begin
              w_state_nxt = S_IDLE;
              w_done      = 1'b1;
            end
          end else begin
            w_load     = 1'b1;
            w_word_nxt = w_down_nxt;
          end
        end else begin
          w_cnt_nxt = r_cnt + DWELL_W'(1);
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Datapath and pulse registers.
  always_ff @(posedge iclk or negedge irstn) begin
    if (!irstn) begin
      r_start <= FW_W'(1);
      r_stop  <= FW_W'(1);
      r_step  <= FW_W'(1);
      r_dwell <= '0;
      r_mode  <= 2'd0;
      r_word  <= FW_W'(1);
      r_cnt   <= '0;
      r_vld   <= 1'b0;
      r_clr   <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_vld  <= w_load;
      r_clr  <= w_clr;
      r_done <= w_done;
      r_err  <= w_err;
      r_cnt  <= w_cnt_nxt;
      if (w_load) begin
        r_word <= w_word_nxt;
      end
      if (w_copy) begin
        r_start <= w_sh_start;
        r_stop  <= w_sh_stop;
        r_step  <= w_sh_step;
        r_dwell <= w_sh_dwell;
        r_mode  <= r_sh_mode;
      end
    end
  end

  assign io_bus.ofreq_word = r_word;
  assign io_bus.ofreq_vld  = r_vld;
  assign io_bus.ophase_clr = r_clr;
  assign io_bus.obusy      = (r_state != S_IDLE);
  assign io_bus.odone      = r_done;
  assign io_bus.oerr       = r_err;

endmodule

// File: doc/dds_sweep_ctrl.md
DDS_SWEEP_CTRL -- requirements
Module: dds_sweep_ctrl

Interface
REQ-001 Parameter FW_W, default 24: frequency word width in bits.
REQ-002 Parameter DWELL_W, default 16: dwell counter width in bits.
REQ-003 iclk  in  1  system clock; all logic rising-edge.
REQ-004 irstn  in  1  reset, asynchronous, active-low.
REQ-005 icfg_wr  in  1  configuration write strobe, one cycle per byte.
REQ-006 icfg_addr  in  4  configuration byte address.
REQ-007 icfg_data  in  8  configuration byte.
REQ-008 istart  in  1  start-sweep request, level sampled each cycle.
REQ-009 istop  in  1  abort request, level sampled each cycle.
REQ-010 ofreq_word  out  FW_W  frequency word for the phase accumulator.
REQ-011 ofreq_vld  out  1  one-cycle pulse in the cycle ofreq_word takes a new value.
REQ-012 ophase_clr  out  1  one-cycle pulse requesting accumulator phase clear.
REQ-013 obusy  out  1  high while in UP or DOWN.
REQ-014 odone  out  1  one-cycle pulse on normal (non-aborted) sweep completion.
REQ-015 oerr  out  1  one-cycle pulse when istart is rejected.

Function
REQ-016 Shadow register map on icfg_wr: 0/1/2 start word bytes [7:0]/[15:8]/[23:16]; 3/4/5 stop word bytes, same order; 6/7 step [7:0]/[15:8]; 8/9 dwell [7:0]/[15:8]; 10 mode (bit0 triangle, bit1 continuous); 11-15 ignored, no side effect.
REQ-017 Shadow writes are accepted in every state and never alter an active sweep.
REQ-018 istart in IDLE copies all shadows into active registers in the same edge.
REQ-019 istart is rejected when shadow start > shadow stop or shadow step == 0: state stays IDLE, oerr pulses one cycle, outputs otherwise unchanged.
REQ-020 istart outside IDLE is ignored.
REQ-021 FSM states: IDLE, UP, DOWN.
REQ-022 Accepted istart -> UP; next cycle ofreq_word = start, ofreq_vld = 1, ophase_clr = 1, dwell counter = 0.
REQ-023 Each word is held dwell+1 cycles; dwell = 0 means a new word every cycle.
REQ-024 UP at dwell expiry: sum = word + step, computed FW_W+1 bits wide; if sum >= stop, word = stop, else word = sum.
REQ-025 Leaving UP: when the loaded word equals stop, at the following dwell expiry: triangle -> DOWN; else continuous -> reload start with ophase_clr pulse, stay UP; else -> IDLE with odone pulse.
REQ-026 DOWN at dwell expiry: if word - step <= start (borrow included), word = start, else word = word - step.
REQ-027 When the loaded word equals start, at the following dwell expiry: continuous -> UP, stepping from start, no ophase_clr; else -> IDLE with odone pulse.
REQ-028 start == stop: a single word is held dwell+1 cycles, then handled per REQ-025, with triangle treated as off.
REQ-029 istop in UP or DOWN -> IDLE next edge; ofreq_word is retained; no odone, no ofreq_vld.
REQ-030 istop and istart in the same cycle: istop wins; istart is ignored and oerr is not asserted.
REQ-031 In IDLE, ofreq_word holds its last value.
REQ-032 ofreq_vld pulses on every ofreq_word register load, including a load of an identical value.

Reset
REQ-033 Reset values: state IDLE; ofreq_word = 1; shadow/active start = 1, stop = 1, step = 1, dwell = 0, mode = 0; all pulse outputs and obusy = 0.
REQ-034 Reset asserted mid-sweep returns the block to the REQ-033 values immediately, asynchronously; no pulse is emitted on release.

Verification
REQ-035 Ramp: start = 0x000010, stop = 0x000040, step = 0x10, dwell = 1, mode = 0, istart -> words 0x10, 0x20, 0x30, 0x40, each held 2 cycles; odone pulses once; obusy is high for 8 cycles.
REQ-036 Overshoot clamp: start = 0x10, stop = 0x35, step = 0x10, dwell = 0 -> words 0x10, 0x20, 0x30, 0x35, then IDLE.
REQ-037 Triangle + continuous: start = 0, stop = 0x30, step = 0x10, dwell = 0, mode = 3 -> words 0, 0x10, 0x20, 0x30, 0x20, 0x10, 0, 0x10 ...; ophase_clr pulses only at the first word.
REQ-038 Rejection: start = 0x50, stop = 0x40, istart -> oerr pulses once, state stays IDLE; repeat with step = 0 -> same result.
REQ-039 Abort and shadow isolation: mid-sweep write stop = 0xFFFFFF, then istop and istart together -> IDLE, word retained, no odone, no oerr; the next istart uses stop = 0xFFFFFF.
REQ-040 Reset mid-sweep at word 0x20 -> ofreq_word = 1, obusy = 0 immediately; sweep does not resume after release.
